cost_rom_arbiter: RTL
=====================

# cost_rom_arbiter

Two-requester round-robin arbiter that shares the single job-cost lookup port (`W`/`J` address in, `Cost` out) between two permutation-search engines. Each engine issues worker/job address beats, optionally in bursts (one per permutation row). The arbiter forwards each granted beat to the cost memory and returns the `Cost` to the requester that issued it. It sits between the search engines and the cost memory, and is the only master of that memory.

## Interface

Parameters:
- `LAT`, 1: cost memory read latency in cycles, 1..3. `Cost` is valid `LAT` cycles after the cycle `RD`=1.
- `TIMEOUT`, 15: idle cycles after which a burst owner loses its lock, 1..255. 0 disables the timeout.

Ports:
- `CLK` in 1: single clock; all logic on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `R0_REQ` in 1: requester 0 beat request.
- `R0_W` in 3: requester 0 worker index.
- `R0_J` in 3: requester 0 job index.
- `R0_LAST` in 1: final beat of requester 0 burst.
- `R0_GNT` out 1: combinational; beat accepted this cycle when `R0_REQ`&`R0_GNT`.
- `R0_VLD` out 1: one-cycle pulse; `R0_COST` holds a returned cost.
- `R0_COST` out 7: returned cost for requester 0.
- `R1_REQ`, `R1_W`, `R1_J`, `R1_LAST`, `R1_GNT`, `R1_VLD`, `R1_COST`: same as the `R0_*` ports, for requester 1.
- `W` out 3: registered worker address to the cost memory.
- `J` out 3: registered job address to the cost memory.
- `RD` out 1: registered read strobe; `W`/`J` are meaningful only when `RD`=1.
- `Cost` in 7: cost memory read data.
- `BUSY` out 1: registered; 1 when state≠IDLE or any read is in flight.

## Operation

- States:
  - IDLE: no owner.
  - OWN0: requester 0 holds a burst lock.
  - OWN1: requester 1 holds a burst lock.
- Round-robin pointer `rr`, 1 bit, names the preferred requester. Reset value 0.
- Grant in IDLE:
  - Only one requester has REQ: it gets GNT.
  - Both have REQ: `rr` side gets GNT.
- Grant in OWNk: `Rk_GNT`=`Rk_REQ`. The other side's GNT=0.
- Accepted beat with `LAST`=0:
  - From IDLE: go to OWNk.
  - In OWNk: stay.
- Accepted beat with `LAST`=1: go to IDLE (from IDLE or OWNk) and set `rr` = other requester. Single-beat transactions use `LAST`=1 from IDLE.
- Any accepted beat updates `rr` to the other side only on the LAST beat. Within a burst, `rr` is unchanged.
- Timeout: idle counter counts consecutive OWNk cycles with `Rk_REQ`=0.
  - When the counter reaches `TIMEOUT`, go to IDLE and set `rr` = other side.
  - The counter clears on any accepted beat and on state entry.
- Return path: a tag pipeline, `LAT`+1 stages of {valid, requester id}, tracks each read. The returned `Cost` is registered into the matching `Rk_COST` with a `Rk_VLD` pulse.
  - The non-matching `COST` register holds its value.
- One beat accepted per cycle maximum. Sustained throughput is 1 beat/cycle with no bubbles, including owner switch from IDLE.
- Address/cost width: 3-bit indices and 7-bit costs pass through unmodified. No arithmetic on data.

## Timing

- Beat accepted in cycle t:
  - `W`/`J`/`RD`=1 in cycle t+1.
  - `Cost` sampled in cycle t+1+`LAT`.
  - `Rk_COST`/`Rk_VLD` valid in cycle t+2+`LAT`.
  - Total latency is `LAT`+2.
- `RD`=0 in any cycle following a cycle with no acceptance. `W`/`J` hold their last value.
- Returns arrive in acceptance order. No reordering across requesters.
- Simultaneous events in one cycle:
  - LAST acceptance and the other side's REQ: the other side is granted no earlier than the next cycle (state is IDLE then, `rr` favours it).
  - A timeout in the same cycle as the owner's REQ rising: the acceptance wins and the counter clears.
- Reset values, synchronous on `RST`:
  - State IDLE, `rr`=0, timeout counter 0, tag pipeline cleared.
  - `W`=0, `J`=0, `RD`=0, `BUSY`=0.
  - `R0_VLD`=`R1_VLD`=0, `R0_COST`=`R1_COST`=0.
  - GNT outputs are 0 while `RST`=1.
- Reset mid-burst or with reads in flight: in-flight costs are dropped and no VLD pulses follow. Requesters must reissue.

## Test plan

- Single beat, `LAT`=1: `R0_REQ`=1, W=2, J=5, LAST=1, Cost memory returns 37 → `R0_GNT`=1 same cycle, `RD`=1 with W=2/J=5 next cycle, `R0_VLD`=1 with `R0_COST`=37 three cycles after accept; `R1_VLD` stays 0.
- Contention after reset: both REQ with LAST=1 continuously → grants alternate R0,R1,R0,R1 and returns alternate correspondingly, each 1 cycle apart.
- Burst lock: R0 issues 8 beats (W=0..7), LAST on W=7, while R1 requests throughout → `R1_GNT`=0 for all 8; R1 granted the cycle after the R0 LAST beat.
- Timeout, `TIMEOUT`=4: R0 accepts one LAST=0 beat then drops REQ, R1 requesting → R1 granted exactly 4 idle cycles later; `rr`=1 afterwards.
- `LAT`=3 back-to-back: 6 alternating beats with distinct costs 10..15 → every cost lands at the correct requester, in order, latency 5.
- Reset mid-operation: assert `RST` with 3 reads in flight → no VLD pulses afterwards; all outputs at reset values; first post-reset contention grants R0.

Source files
------------

// File: rtl/cost_rom_arbiter.sv
// Two-requester round-robin arbiter sharing one cost-memory read port, with
// burst locking, owner idle timeout and a tag pipeline that routes returned costs.
module cost_rom_arbiter #(
   parameter int LAT     = 1,
   parameter int TIMEOUT = 15
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       R0_REQ,
   input  logic [2:0] R0_W,
   input  logic [2:0] R0_J,
   input  logic       R0_LAST,
   output logic       R0_GNT,
   output logic       R0_VLD,
   output logic [6:0] R0_COST,
   input  logic       R1_REQ,
   input  logic [2:0] R1_W,
   input  logic [2:0] R1_J,
   input  logic       R1_LAST,
   output logic       R1_GNT,
   output logic       R1_VLD,
   output logic [6:0] R1_COST,
   output logic [2:0] W,
   output logic [2:0] J,
   output logic       RD,
   input  logic [6:0] Cost,
   output logic       BUSY
);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t       state_r;
   logic         rr_r;
   logic [7:0]   idle_cnt_r;
   logic [LAT:0] tag_v_r;
   logic [LAT:0] tag_id_r;
   logic         gnt0_s;
   logic         gnt1_s;
   logic         acc_s;
   logic         acc_id_s;
   logic         acc_last_s;
   logic         owner_s;
   logic [2:0]   acc_w_s;
   logic [2:0]   acc_j_s;

   // Grant decision: round-robin when unlocked, owner-only while a burst holds the lock
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (RST) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               gnt0_s = R0_REQ & (~R1_REQ | ~rr_r);
               gnt1_s = R1_REQ & (~R0_REQ | rr_r);
            end
            OWN0:    gnt0_s = R0_REQ;
            OWN1:    gnt1_s = R1_REQ;
            default: begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
         endcase
      end
   end

   assign R0_GNT     = gnt0_s;
   assign R1_GNT     = gnt1_s;
   assign acc_s      = gnt0_s | gnt1_s;
   assign acc_id_s   = gnt1_s;
   assign acc_last_s = gnt1_s ? R1_LAST : R0_LAST;
   assign acc_w_s    = gnt1_s ? R1_W : R0_W;
   assign acc_j_s    = gnt1_s ? R1_J : R0_J;
   assign owner_s    = (state_r == OWN1);

   // Lock state, round-robin pointer and owner idle timeout
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= IDLE;
         rr_r       <= 1'b0;
         idle_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               idle_cnt_r <= 8'd0;
               if (acc_s) begin
                  if (acc_last_s) begin
                     rr_r <= ~acc_id_s;
                  end else begin
                     state_r <= acc_id_s ? OWN1 : OWN0;
                  end
               end
            end
            OWN0, OWN1: begin
               if (acc_s) begin
                  idle_cnt_r <= 8'd0;
                  if (acc_last_s) begin
                     state_r <= IDLE;
                     rr_r    <= ~acc_id_s;
                  end
               end else if ((TO != 8'd0) && (idle_cnt_r == TO - 8'd1)) begin
                  // A stalled owner gives up the lock and the other side is preferred next
                  state_r    <= IDLE;
                  rr_r       <= ~owner_s;
                  idle_cnt_r <= 8'd0;
               end else if (TO != 8'd0) begin
                  idle_cnt_r <= idle_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r    <= IDLE;
               idle_cnt_r <= 8'd0;
            end
         endcase
      end
   end

   // Memory request registers, tag pipeline and per-requester return registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         W        <= 3'd0;
         J        <= 3'd0;
         RD       <= 1'b0;
         BUSY     <= 1'b0;
         tag_v_r  <= '0;
         tag_id_r <= '0;
         R0_VLD   <= 1'b0;
         R1_VLD   <= 1'b0;
         R0_COST  <= 7'd0;
         R1_COST  <= 7'd0;
      end else begin
         RD <= acc_s;
         if (acc_s) begin
            W <= acc_w_s;
            J <= acc_j_s;
         end
         // Stage LAT lines up with the cycle in which Cost carries that read's data
         tag_v_r  <= {tag_v_r[LAT-1:0], acc_s};
         tag_id_r <= {tag_id_r[LAT-1:0], acc_id_s};
         BUSY     <= (state_r != IDLE) | acc_s | (|tag_v_r);
         R0_VLD   <= tag_v_r[LAT] & ~tag_id_r[LAT];
         R1_VLD   <= tag_v_r[LAT] & tag_id_r[LAT];
         if (tag_v_r[LAT] && !tag_id_r[LAT]) begin
            R0_COST <= Cost;
         end
         if (tag_v_r[LAT] && tag_id_r[LAT]) begin
            R1_COST <= Cost;
         end
      end
   end

endmodule
